// File: rtl/attn_pkg.sv
// Shared defaults and FSM encoding for the attention dispatcher and its
// round-robin picker.
package attn_pkg;

  localparam int unsigned DEF_N_LINES = 6;
  localparam int unsigned DEF_ID_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } state_t;

  // Successor of idx in a ring of n entries.
  function automatic int unsigned wrapInc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set pend bit at or after ptr,
// wrapping around the ring of N_LINES entries.
module rr_pick
  import attn_pkg::*;
#(
  parameter int unsigned N_LINES = DEF_N_LINES,
  parameter int unsigned ID_W    = DEF_ID_W
) (
  input  logic [N_LINES-1:0] pend,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  function automatic logic [ID_W-1:0] candIdx(input logic [ID_W-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= N_LINES) sum = sum - N_LINES;
    return ID_W'(sum);
  endfunction

  // Scan from the farthest offset down so the closest candidate to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_LINES - 1; k >= 0; k--) begin
      if (pend[candIdx(ptr, k)]) begin
        found = 1'b1;
        idx   = candIdx(ptr, k);
      end
    end
  end

endmodule

// File: rtl/attn_dispatch.sv
// Attention dispatcher: latches rising edges of the request lines, offers
// pending lines round-robin to a service engine and guards each service
// with a timeout.
module attn_dispatch
  import attn_pkg::*;
#(
  parameter int unsigned N_LINES = DEF_N_LINES,
  parameter int unsigned ID_W    = DEF_ID_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LINES-1:0] req,
  output logic               svc_valid,
  input  logic               svc_ready,
  output logic [ID_W-1:0]    svc_id,
  input  logic               done,
  output logic [N_LINES-1:0] pend,
  output logic               busy,
  output logic               timeout_err,
  input  logic               err_clr
);

  localparam int unsigned      TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [N_LINES-1:0] r_reqQ;
  logic [N_LINES-1:0] r_pend;
  logic [N_LINES-1:0] w_rise;
  logic [N_LINES-1:0] w_clrMask;
  logic [N_LINES-1:0] w_pendNext;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_svcId;
  logic [ID_W-1:0]    w_pickIdx;
  logic [TMR_W-1:0]   r_timer;
  logic               r_timeoutErr;
  logic               w_pickFound;
  logic               w_accept;
  logic               w_finish;
  logic               w_expire;

  rr_pick #(
    .N_LINES (N_LINES),
    .ID_W    (ID_W)
  ) u_pick (
    .pend  (r_pend),
    .ptr   (r_ptr),
    .found (w_pickFound),
    .idx   (w_pickIdx)
  );

  assign w_rise   = req & ~r_reqQ;
  assign w_accept = (r_state == OFFER) && svc_ready;
  assign w_finish = (r_state == BUSY) && done;
  assign w_expire = (r_state == BUSY) && !done && (r_timer == TMR_LAST);

  // A fresh rising edge on the line being retired keeps it pending.
  assign w_clrMask  = (w_finish || w_expire) ? (N_LINES'(1) << r_svcId) : '0;
  assign w_pendNext = (r_pend & ~w_clrMask) | w_rise;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_pickFound) w_nextState = OFFER;
      OFFER:   if (svc_ready) w_nextState = BUSY;
      BUSY:    if (w_finish || w_expire) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    svc_valid = (r_state == OFFER);
    busy      = (r_state == BUSY);
  end

  // svc_id only moves on a pick in IDLE, so it stays frozen through OFFER/BUSY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_reqQ       <= '0;
      r_pend       <= '0;
      r_ptr        <= '0;
      r_svcId      <= '0;
      r_timer      <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_reqQ <= req;
      r_pend <= w_pendNext;
      if ((r_state == IDLE) && w_pickFound) begin
        r_svcId <= w_pickIdx;
      end
      if (w_accept) begin
        r_ptr   <= ID_W'(wrapInc(32'(r_svcId), N_LINES));
        r_timer <= '0;
      end else if (r_state == BUSY) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_expire) begin
        r_timeoutErr <= 1'b1;
      end else if (err_clr) begin
        r_timeoutErr <= 1'b0;
      end
    end
  end

  assign pend        = r_pend;
  assign svc_id      = r_svcId;
  assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_attn_dispatch.sv
// Directed bench for attn_dispatch: a per-cycle vector table for dispatch and
// round-robin order, plus hand-written timeout, stall, collision and reset runs.
module tb_attn_dispatch;

  localparam int unsigned N   = 6;
  localparam int unsigned IDW = 3;
  localparam int unsigned TMO = 8;

  typedef struct packed {
    logic           rstN;
    logic [N-1:0]   req;
    logic           rdy;
    logic           dn;
    logic           clr;
    logic           expValid;
    logic [IDW-1:0] expId;
    logic [N-1:0]   expPend;
    logic           expBusy;
    logic           expErr;
  } vec_t;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic           svc_valid;
  logic           svc_ready;
  logic [IDW-1:0] svc_id;
  logic           done;
  logic [N-1:0]   pend;
  logic           busy;
  logic           timeout_err;
  logic           err_clr;

  int passCount;
  int checkCount;
  vec_t vecs[$];

  attn_dispatch #(
    .N_LINES (N),
    .ID_W    (IDW),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .svc_valid   (svc_valid),
    .svc_ready   (svc_ready),
    .svc_id      (svc_id),
    .done        (done),
    .pend        (pend),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive inputs for one rising edge, then settle 1ns past it for sampling.
  task automatic applyStimulus(input logic rs, input logic [N-1:0] rq, input logic rd,
                               input logic dn, input logic cl);
    rst_n     = rs;
    req       = rq;
    svc_ready = rd;
    done      = dn;
    err_clr   = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string name, input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic eValid, input logic [IDW-1:0] eId,
                             input logic [N-1:0] ePend, input logic eBusy, input logic eErr);
    checkField({tag, ".svc_valid"},   8'(svc_valid),   8'(eValid));
    checkField({tag, ".svc_id"},      8'(svc_id),      8'(eId));
    checkField({tag, ".pend"},        8'(pend),        8'(ePend));
    checkField({tag, ".busy"},        8'(busy),        8'(eBusy));
    checkField({tag, ".timeout_err"}, 8'(timeout_err), 8'(eErr));
  endtask

  task automatic stepCheck(input string tag, input logic rs, input logic [N-1:0] rq,
                           input logic rd, input logic dn, input logic cl,
                           input logic eValid, input logic [IDW-1:0] eId,
                           input logic [N-1:0] ePend, input logic eBusy, input logic eErr);
    applyStimulus(rs, rq, rd, dn, cl);
    checkOutput(tag, eValid, eId, ePend, eBusy, eErr);
  endtask

  task automatic addVec(input logic rs, input logic [N-1:0] rq, input logic rd, input logic dn,
                        input logic cl, input logic eValid, input logic [IDW-1:0] eId,
                        input logic [N-1:0] ePend, input logic eBusy, input logic eErr);
    vec_t v;
    v = '{rs, rq, rd, dn, cl, eValid, eId, ePend, eBusy, eErr};
    vecs.push_back(v);
  endtask

  // Line 0 is offered and accepted, then left BUSY for TMO cycles; the last
  // BUSY edge optionally carries done, which must beat the timeout.
  task automatic serviceLine0(input string tag, input logic [IDW-1:0] prevId,
                              input logic clrIn, input logic doneLast);
    stepCheck({tag, ".req"},    1, 6'h01, 0, 0, clrIn, 0, prevId, 6'h01, 0, 0);
    stepCheck({tag, ".offer"},  1, 6'h00, 0, 0, clrIn, 1, 3'd0,   6'h01, 0, 0);
    stepCheck({tag, ".accept"}, 1, 6'h00, 1, 0, clrIn, 0, 3'd0,   6'h01, 1, 0);
    for (int c = 1; c < int'(TMO); c++) begin
      stepCheck($sformatf("%s.busy%0d", tag, c), 1, 6'h00, 0, 0, clrIn, 0, 3'd0, 6'h01, 1, 0);
    end
    stepCheck({tag, ".end"}, 1, 6'h00, 0, doneLast, clrIn, 0, 3'd0, 6'h00, 0, !doneLast);
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    rst_n      = 1'b0;
    req        = '0;
    svc_ready  = 1'b0;
    done       = 1'b0;
    err_clr    = 1'b0;

    //     rst req    rdy dn clr | val id    pend   busy err
    addVec(0, 6'h00, 0, 0, 0,    0, 3'd0, 6'h00, 0, 0);
    addVec(1, 6'h00, 0, 0, 0,    0, 3'd0, 6'h00, 0, 0);
    addVec(1, 6'h08, 0, 0, 0,    0, 3'd0, 6'h08, 0, 0);
    addVec(1, 6'h08, 0, 0, 0,    1, 3'd3, 6'h08, 0, 0);
    addVec(1, 6'h00, 1, 0, 0,    0, 3'd3, 6'h08, 1, 0);
    addVec(1, 6'h00, 0, 0, 0,    0, 3'd3, 6'h08, 1, 0);
    addVec(1, 6'h00, 0, 1, 0,    0, 3'd3, 6'h00, 0, 0);
    addVec(1, 6'h00, 0, 1, 0,    0, 3'd3, 6'h00, 0, 0);
    addVec(0, 6'h00, 0, 0, 0,    0, 3'd0, 6'h00, 0, 0);
    addVec(1, 6'h12, 0, 0, 0,    0, 3'd0, 6'h12, 0, 0);
    addVec(1, 6'h00, 1, 0, 0,    1, 3'd1, 6'h12, 0, 0);
    addVec(1, 6'h00, 1, 0, 0,    0, 3'd1, 6'h12, 1, 0);
    addVec(1, 6'h00, 0, 1, 0,    0, 3'd1, 6'h10, 0, 0);
    addVec(1, 6'h02, 1, 0, 0,    1, 3'd4, 6'h12, 0, 0);
    addVec(1, 6'h00, 1, 0, 0,    0, 3'd4, 6'h12, 1, 0);
    addVec(1, 6'h00, 0, 1, 0,    0, 3'd4, 6'h02, 0, 0);
    addVec(1, 6'h10, 1, 0, 0,    1, 3'd1, 6'h12, 0, 0);
    addVec(1, 6'h00, 1, 0, 0,    0, 3'd1, 6'h12, 1, 0);
    addVec(1, 6'h00, 0, 1, 0,    0, 3'd1, 6'h10, 0, 0);
    addVec(1, 6'h02, 1, 0, 0,    1, 3'd4, 6'h12, 0, 0);
    addVec(1, 6'h00, 1, 0, 0,    0, 3'd4, 6'h12, 1, 0);
    addVec(1, 6'h00, 0, 1, 0,    0, 3'd4, 6'h02, 0, 0);
    addVec(1, 6'h00, 0, 0, 0,    1, 3'd1, 6'h02, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].req, vecs[i].rdy, vecs[i].dn, vecs[i].clr);
      checkOutput($sformatf("v%0d", i), vecs[i].expValid, vecs[i].expId,
                  vecs[i].expPend, vecs[i].expBusy, vecs[i].expErr);
    end

    // Offer of line 1 stalls with ready low; done pulses must not disturb it.
    for (int i = 0; i < 10; i++) begin
      stepCheck($sformatf("stall%0d", i), 1, 6'h00, 0, 1'(i % 2), 0, 1, 3'd1, 6'h02, 0, 0);
    end
    stepCheck("stall.accept", 1, 6'h00, 1, 0, 0, 0, 3'd1, 6'h02, 1, 0);
    stepCheck("stall.done",   1, 6'h00, 0, 1, 0, 0, 3'd1, 6'h00, 0, 0);

    serviceLine0("tmo1", 3'd1, 0, 0);
    stepCheck("tmo1.hold", 1, 6'h00, 0, 0, 0, 0, 3'd0, 6'h00, 0, 1);
    stepCheck("tmo1.clr",  1, 6'h00, 0, 0, 1, 0, 3'd0, 6'h00, 0, 0);
    serviceLine0("tmo2", 3'd0, 1, 0);
    stepCheck("tmo2.clr",  1, 6'h00, 0, 0, 1, 0, 3'd0, 6'h00, 0, 0);
    serviceLine0("tmo3", 3'd0, 0, 1);

    // done and a new req[2] edge land together: line 2 stays pending.
    stepCheck("col.req",    1, 6'h04, 0, 0, 0, 0, 3'd0, 6'h04, 0, 0);
    stepCheck("col.offer",  1, 6'h00, 0, 0, 0, 1, 3'd2, 6'h04, 0, 0);
    stepCheck("col.accept", 1, 6'h00, 1, 0, 0, 0, 3'd2, 6'h04, 1, 0);
    stepCheck("col.done",   1, 6'h04, 0, 1, 0, 0, 3'd2, 6'h04, 0, 0);
    stepCheck("col.reoff",  1, 6'h04, 0, 0, 0, 1, 3'd2, 6'h04, 0, 0);
    stepCheck("col.busy",   1, 6'h00, 1, 0, 0, 0, 3'd2, 6'h04, 1, 0);

    // Reset mid-BUSY with req[5] held high across release.
    stepCheck("rst.req5",  1, 6'h20, 0, 0, 0, 0, 3'd2, 6'h24, 1, 0);
    stepCheck("rst.low",   0, 6'h20, 0, 0, 0, 0, 3'd0, 6'h00, 0, 0);
    stepCheck("rst.rel",   1, 6'h20, 0, 0, 0, 0, 3'd0, 6'h20, 0, 0);
    stepCheck("rst.offer", 1, 6'h20, 0, 0, 0, 1, 3'd5, 6'h20, 0, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
